// File: rtl/uart_frame_arbiter.sv
// rtl/uart_frame_arbiter.sv - round-robin arbiter sharing one 5-byte UART frame sender
//
// Purpose:
//   Shares one 5-byte UART frame sender (Trans_go / Data / all_done) among
//   NUM_REQ requesters. The winner is chosen round-robin, and its 40-bit
//   payload is latched. trans_go is held until the sender reports all_done.
//   The owner then gets a one-cycle done pulse. After every frame the sender
//   gets at least GAP_CYCLES idle cycles, and it must drop all_done before
//   the next launch.
//
// Parameters:
//   NUM_REQ        number of requesters (2..8)
//   GAP_CYCLES     minimum idle cycles after completion (1..255)
//   TIMEOUT_CYCLES BUSY watchdog limit, used only with ARB_TIMEOUT_EN
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a 20-bit watchdog aborts a frame that is stuck in BUSY.
//   When undefined, timeout_err is tied to 0.
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req          in   [NUM_REQ]     level request per requester
//   req_data     in   [NUM_REQ*40]  payload, slice i = [40*i+39:40*i]
//   grant        out  [NUM_REQ]     one-hot 1-cycle pulse, payload taken
//   done         out  [NUM_REQ]     one-hot 1-cycle pulse, frame finished
//   trans_go     out  to sender Trans_go
//   tx_data      out  [40]          to sender Data, stable while trans_go=1
//   all_done     in   from sender, frame complete
//   busy         out  high in any state other than IDLE
//   timeout_err  out  1-cycle pulse on watchdog abort
module uart_frame_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*40-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic                  trans_go,
  output logic [39:0]           tx_data,
  input  logic                  all_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int         OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1048576) begin : g_bad_cfg
    $error("uart_frame_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_q, last_d;
  logic [7:0]        gap_q, gap_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic              trans_go_q, trans_go_d;
  logic [39:0]       tx_data_q, tx_data_d;
  logic              busy_q, busy_d;

  logic              wd_hit;
  logic              win_vld;
  logic [OW-1:0]     win_idx;
  logic [OW-1:0]     cand;

`ifdef ARB_TIMEOUT_EN
  logic [19:0]       wd_q, wd_d;
  logic              terr_q, terr_d;
  assign wd_hit = (wd_q == 20'(TIMEOUT_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  // Round-robin search: scan upward from last_owner+1, wrapping, with the
  // previous owner checked last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = OW'((int'(last_q) + off) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_vld) state_d = S_BUSY;
      S_BUSY: if (all_done || wd_hit) state_d = S_GAP;
      // all_done still high holds GAP so a stale completion can't end the
      // next frame
      S_GAP:  if (gap_q == GAP_LAST && !all_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    grant_d    = '0;
    done_d     = '0;
    trans_go_d = trans_go_q;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gap_d      = gap_q;
    busy_d     = (state_d != S_IDLE);
`ifdef ARB_TIMEOUT_EN
    wd_d       = wd_q;
    terr_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d    = NUM_REQ'(1) << win_idx;
          tx_data_d  = req_data[40*win_idx +: 40];
          trans_go_d = 1'b1;
          owner_d    = win_idx;
`ifdef ARB_TIMEOUT_EN
          wd_d       = '0;
`endif
        end else begin
          trans_go_d = 1'b0;
          tx_data_d  = '0;
        end
      end
      S_BUSY: begin
        if (all_done || wd_hit) begin
          trans_go_d = 1'b0;
          tx_data_d  = '0;
          done_d     = NUM_REQ'(1) << owner_q;
          last_d     = owner_q;
          gap_d      = '0;
`ifdef ARB_TIMEOUT_EN
          terr_d     = !all_done;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          wd_d       = wd_q + 20'd1;
`endif
        end
      end
      S_GAP: begin
        // Saturate so a long all_done hold cannot wrap the counter.
        if (gap_q != GAP_LAST) gap_d = gap_q + 8'd1;
      end
      default: begin
        trans_go_d = 1'b0;
        tx_data_d  = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      last_q     <= OW'(NUM_REQ - 1);
      gap_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      trans_go_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      trans_go_q <= trans_go_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign grant    = grant_q;
  assign done     = done_q;
  assign trans_go = trans_go_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb/tb_uart_frame_arbiter.sv - directed self-checking bench for uart_frame_arbiter
module tb_uart_frame_arbiter;
  localparam int N   = 4;
  localparam int GAP = 2;

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic [N-1:0]  req     = '0;
  logic [N*40-1:0] req_data = '0;
  logic [N-1:0]  grant, done;
  logic          trans_go, all_done = 1'b0, busy, timeout_err;
  logic [39:0]   tx_data;

  int total = 0;
  int bad   = 0;

  uart_frame_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(50)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .trans_go(trans_go), .tx_data(tx_data),
    .all_done(all_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; all_done = 1'b0; req_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int go_cnt, low_run, min_gap, to_at;
    bit seen;

    // reset state
    do_reset();
    check("rst_grant", 64'(grant), 0);
    check("rst_done", 64'(done), 0);
    check("rst_trans_go", 64'(trans_go), 0);
    check("rst_tx_data", 64'(tx_data), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_timeout", 64'(timeout_err), 0);

    // single frame from requester 2
    req_data[80 +: 40] = 40'h10_08_04_02_01;
    req = 4'b0100;
    tick();
    check("t1_grant", 64'(grant), 64'h4);
    check("t1_go", 64'(trans_go), 1);
    check("t1_data", 64'(tx_data), 64'h10_08_04_02_01);
    check("t1_busy", 64'(busy), 1);
    req = '0;
    tick();
    check("t1_grant_pulse", 64'(grant), 0);
    check("t1_go_hold", 64'(trans_go), 1);
    check("t1_data_hold", 64'(tx_data), 64'h10_08_04_02_01);
    all_done = 1'b1;
    tick();
    all_done = 1'b0;
    check("t1_done", 64'(done), 64'h4);
    check("t1_go_off", 64'(trans_go), 0);
    tick();
    check("t1_done_pulse", 64'(done), 0);
    check("t1_busy_gap", 64'(busy), 1);
    tick();
    check("t1_busy_idle", 64'(busy), 0);

    // round-robin with all requesters, sender completes 10 cycles after trans_go
    do_reset();
    for (int i = 0; i < N; i++) req_data[40*i +: 40] = 40'(64'hA0 + i);
    req = 4'b1111;
    go_cnt = 0; low_run = 0; min_gap = 1000; seen = 0;
    for (int c = 0; c < 300 && order.size() < 5; c++) begin
      tick();
      for (int b = 0; b < N; b++) if (grant[b]) order.push_back(b);
      if (trans_go) begin
        if (seen && low_run > 0 && low_run < min_gap) min_gap = low_run;
        low_run = 0; seen = 1; go_cnt++;
        all_done = (go_cnt == 10);
      end else begin
        go_cnt = 0; all_done = 1'b0;
        if (seen) low_run++;
      end
    end
    check("rr_count", 64'(order.size()), 5);
    for (int i = 0; i < order.size() && i < 5; i++)
      check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(exp_order[i]));
    check("rr_gap_ok", 64'(min_gap >= GAP && min_gap < 1000), 1);

    // BUSY ignores req and payload changes
    do_reset();
    req_data[0 +: 40] = 40'h11_22_33_44_55;
    req = 4'b0001;
    tick();
    check("t3_grant", 64'(grant), 64'h1);
    for (int k = 0; k < 3; k++) begin
      req = (k % 2 == 0) ? 4'b1110 : 4'b1111;
      req_data[0 +: 40] = 40'(64'hDEAD00 + k);
      tick();
      check($sformatf("t3_data%0d", k), 64'(tx_data), 64'h11_22_33_44_55);
      check($sformatf("t3_nogrant%0d", k), 64'(grant), 0);
      check($sformatf("t3_go%0d", k), 64'(trans_go), 1);
    end

    // all_done held high after completion keeps the arbiter in GAP
    req = 4'b0010;
    all_done = 1'b1;
    tick();
    check("t4_done", 64'(done), 64'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t4_hold_busy%0d", k), 64'(busy), 1);
      check($sformatf("t4_hold_nogrant%0d", k), 64'(grant), 0);
    end
    all_done = 1'b0;
    tick();
    check("t4_idle", 64'(busy), 0);
    check("t4_idle_nogrant", 64'(grant), 0);
    tick();
    check("t4_grant", 64'(grant), 64'h2);

    // asynchronous reset mid-BUSY
    req = '0;
    tick();
    check("t5_pre_go", 64'(trans_go), 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_go", 64'(trans_go), 0);
    check("t5_async_data", 64'(tx_data), 0);
    check("t5_async_busy", 64'(busy), 0);
    tick();
    check("t5_no_done", 64'(done), 0);
    rst_n = 1'b1;
    req = 4'b1010;
    tick();
    check("t5_grant", 64'(grant), 64'h2);
    check("t5_no_done2", 64'(done), 0);

`ifdef ARB_TIMEOUT_EN
    // watchdog abort with a silent sender
    do_reset();
    req = 4'b1100;
    tick();
    check("t6_grant", 64'(grant), 64'h4);
    req = 4'b1000;
    to_at = -1;
    for (int c = 1; c <= 60 && to_at < 0; c++) begin
      tick();
      if (timeout_err) begin
        to_at = c;
        check("t6_done", 64'(done), 64'h4);
      end
    end
    check("t6_timeout_at", 64'(to_at), 50);
    tick(); tick(); tick();
    check("t6_next_grant", 64'(grant), 64'h8);
`else
    check("t6_timeout_tied", 64'(timeout_err), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
